link_activity_monitor: RTL and testbench

- Produces the per-port status and event signals consumed by the port LED driver: debounced `has_link`, single-cycle `on_frame_sent`/`on_frame_received` pulses, and a free-running `blink` square wave.
- Taps the MAC-side TX and RX AXI-Stream handshakes passively; never drives `tready`.
- Also keeps wrapping TX/RX/RX-error frame counters for register readout.
- One instance per 10G port, in the port clock domain.

---
 rtl/link_activity_monitor.sv | 99 +++++++++
 tb/tb_link_activity_monitor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/link_activity_monitor.sv
// link_activity_monitor: debounced link state, frame pulses/counters and blink for the port LED driver
module link_activity_monitor #(
    parameter int BLINK_HALF_PERIOD = 7812500,
    parameter int LINK_DEBOUNCE     = 1024,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 link_status_raw,
    input  logic                 tx_tvalid,
    input  logic                 tx_tready,
    input  logic                 tx_tlast,
    input  logic                 rx_tvalid,
    input  logic                 rx_tready,
    input  logic                 rx_tlast,
    input  logic                 rx_tuser,
    input  logic                 count_clear,
    output logic                 has_link,
    output logic                 on_frame_sent,
    output logic                 on_frame_received,
    output logic                 blink,
    output logic [CNT_WIDTH-1:0] tx_frame_count,
    output logic [CNT_WIDTH-1:0] rx_frame_count,
    output logic [CNT_WIDTH-1:0] rx_err_count
);
    localparam int DW = LINK_DEBOUNCE > 1 ? $clog2(LINK_DEBOUNCE) : 1;
    localparam int BW = $clog2(BLINK_HALF_PERIOD);
    localparam logic [DW-1:0] D_MAX = DW'(LINK_DEBOUNCE - 1);
    localparam logic [BW-1:0] B_MAX = BW'(BLINK_HALF_PERIOD - 1);

    typedef enum logic {DOWN, UP} state_t;

    state_t        state, state_nxt;
    logic [1:0]    sync;
    logic          link_sync;
    logic          mismatch;
    logic [DW-1:0] dcnt, dcnt_nxt;
    logic [BW-1:0] bcnt;
    logic          tx_end, rx_end, rx_bad;

    assign link_sync = sync[1];
    assign has_link  = state == UP;
    assign mismatch  = link_sync != has_link;
    assign tx_end    = tx_tvalid & tx_tready & tx_tlast;
    assign rx_end    = rx_tvalid & rx_tready & rx_tlast;
    assign rx_bad    = rx_end & rx_tuser;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= '0;
            state <= DOWN;
            dcnt  <= '0;
        end else begin
            sync  <= {sync[0], link_status_raw};
            state <= state_nxt;
            dcnt  <= dcnt_nxt;
        end
    end

    // a mismatch must survive LINK_DEBOUNCE consecutive cycles before the state flips
    always_comb begin
        state_nxt = (mismatch && dcnt == D_MAX) ? (state == UP ? DOWN : UP) : state;
        dcnt_nxt  = (mismatch && dcnt != D_MAX) ? dcnt + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bcnt  <= '0;
            blink <= 1'b0;
        end else if (bcnt == B_MAX) begin
            bcnt  <= '0;
            blink <= ~blink;
        end else begin
            bcnt <= bcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            on_frame_sent     <= 1'b0;
            on_frame_received <= 1'b0;
        end else begin
            on_frame_sent     <= tx_end;
            on_frame_received <= rx_end;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || count_clear) begin
            tx_frame_count <= '0;
            rx_frame_count <= '0;
            rx_err_count   <= '0;
        end else begin
            tx_frame_count <= tx_frame_count + CNT_WIDTH'(tx_end);
            rx_frame_count <= rx_frame_count + CNT_WIDTH'(rx_end);
            rx_err_count   <= rx_err_count + CNT_WIDTH'(rx_bad);
        end
    end
endmodule

// File: tb/tb_link_activity_monitor.sv
// tb_link_activity_monitor: directed checks of pulses, counters, debounce, blink and reset behaviour
module tb_link_activity_monitor;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       link_status_raw = 1'b0;
    logic       tx_tvalid = 1'b0, tx_tready = 1'b0, tx_tlast = 1'b0;
    logic       rx_tvalid = 1'b0, rx_tready = 1'b0, rx_tlast = 1'b0, rx_tuser = 1'b0;
    logic       count_clear = 1'b0;
    logic       has_link, on_frame_sent, on_frame_received, blink;
    logic [3:0] tx_frame_count, rx_frame_count, rx_err_count;
    int         n_tests = 0;
    int         n_fail = 0;
    int         pulses;

    link_activity_monitor #(
        .BLINK_HALF_PERIOD(4),
        .LINK_DEBOUNCE(3),
        .CNT_WIDTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .link_status_raw(link_status_raw),
        .tx_tvalid(tx_tvalid),
        .tx_tready(tx_tready),
        .tx_tlast(tx_tlast),
        .rx_tvalid(rx_tvalid),
        .rx_tready(rx_tready),
        .rx_tlast(rx_tlast),
        .rx_tuser(rx_tuser),
        .count_clear(count_clear),
        .has_link(has_link),
        .on_frame_sent(on_frame_sent),
        .on_frame_received(on_frame_received),
        .blink(blink),
        .tx_frame_count(tx_frame_count),
        .rx_frame_count(rx_frame_count),
        .rx_err_count(rx_err_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tx_set(input logic v, input logic r, input logic l);
        tx_tvalid = v;
        tx_tready = r;
        tx_tlast  = l;
    endtask

    task automatic rx_set(input logic v, input logic r, input logic l, input logic u);
        rx_tvalid = v;
        rx_tready = r;
        rx_tlast  = l;
        rx_tuser  = u;
    endtask

    initial begin
        repeat (3) tick;
        chk("rst_has_link", 32'(has_link), 0);
        chk("rst_sent", 32'(on_frame_sent), 0);
        chk("rst_recv", 32'(on_frame_received), 0);
        chk("rst_blink", 32'(blink), 0);
        chk("rst_tx_cnt", 32'(tx_frame_count), 0);
        chk("rst_rx_cnt", 32'(rx_frame_count), 0);
        chk("rst_err_cnt", 32'(rx_err_count), 0);

        reset = 1'b0;
        chk("blink_c0", 32'(blink), 0);
        for (int k = 1; k <= 9; k++) begin
            tick;
            chk($sformatf("blink_c%0d", k), 32'(blink), 32'((k / 4) % 2));
        end
        reset = 1'b1;
        tick;
        chk("blink_reset", 32'(blink), 0);
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick;
            chk($sformatf("blink_restart_%0d", k), 32'(blink), 32'(k == 4));
        end

        tx_set(1, 1, 1);
        tick;
        chk("tx_b2b1_pulse", 32'(on_frame_sent), 1);
        chk("tx_b2b1_cnt", 32'(tx_frame_count), 1);
        tick;
        chk("tx_b2b2_pulse", 32'(on_frame_sent), 1);
        tick;
        chk("tx_b2b3_pulse", 32'(on_frame_sent), 1);
        chk("tx_b2b3_cnt", 32'(tx_frame_count), 3);
        tx_set(1, 1, 0);
        tick;
        chk("tx_f4_beat1", 32'(on_frame_sent), 0);
        tx_set(1, 0, 0);
        tick;
        chk("tx_f4_stall", 32'(on_frame_sent), 0);
        tx_set(1, 1, 0);
        tick;
        chk("tx_f4_beat2", 32'(on_frame_sent), 0);
        tick;
        chk("tx_f4_beat3", 32'(on_frame_sent), 0);
        chk("tx_f4_cnt_mid", 32'(tx_frame_count), 3);
        tx_set(1, 1, 1);
        tick;
        chk("tx_f4_last_pulse", 32'(on_frame_sent), 1);
        chk("tx_f4_cnt", 32'(tx_frame_count), 4);
        tx_set(1, 0, 1);
        tick;
        chk("tx_stalled_last", 32'(on_frame_sent), 0);
        chk("tx_stalled_cnt", 32'(tx_frame_count), 4);
        tx_set(0, 0, 0);
        tick;
        chk("tx_idle", 32'(on_frame_sent), 0);

        rx_set(1, 1, 0, 1);
        tick;
        chk("rx_f1_beat1", 32'(on_frame_received), 0);
        chk("rx_f1_beat1_err", 32'(rx_err_count), 0);
        rx_set(1, 1, 1, 0);
        tick;
        chk("rx_f1_pulse", 32'(on_frame_received), 1);
        chk("rx_f1_cnt", 32'(rx_frame_count), 1);
        chk("rx_f1_err", 32'(rx_err_count), 0);
        rx_set(1, 1, 1, 1);
        tick;
        chk("rx_f2_err", 32'(rx_err_count), 1);
        tick;
        chk("rx_f3_pulse", 32'(on_frame_received), 1);
        chk("rx_f3_cnt", 32'(rx_frame_count), 3);
        chk("rx_f3_err", 32'(rx_err_count), 2);
        rx_set(1, 0, 1, 1);
        tick;
        chk("rx_stalled", 32'(on_frame_received), 0);
        chk("rx_stalled_cnt", 32'(rx_frame_count), 3);
        rx_set(1, 1, 1, 1);
        count_clear = 1'b1;
        tick;
        chk("clr_pulse", 32'(on_frame_received), 1);
        chk("clr_rx_cnt", 32'(rx_frame_count), 0);
        chk("clr_err_cnt", 32'(rx_err_count), 0);
        chk("clr_tx_cnt", 32'(tx_frame_count), 0);
        count_clear = 1'b0;
        rx_set(0, 0, 0, 0);
        tick;
        chk("clr_after_pulse", 32'(on_frame_received), 0);
        chk("clr_after_cnt", 32'(rx_frame_count), 0);

        link_status_raw = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick;
            chk($sformatf("link_up_%0d", k), 32'(has_link), 32'(k == 5));
        end
        link_status_raw = 1'b0;
        repeat (2) tick;
        link_status_raw = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick;
            chk($sformatf("link_glitch_%0d", k), 32'(has_link), 1);
        end
        link_status_raw = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick;
            chk($sformatf("link_down_%0d", k), 32'(has_link), 32'(k < 5));
        end

        pulses = 0;
        tx_set(1, 1, 1);
        for (int i = 1; i <= 17; i++) begin
            tick;
            pulses += int'(on_frame_sent);
            if (i == 16) chk("wrap_cnt16", 32'(tx_frame_count), 0);
        end
        tx_set(0, 0, 0);
        tick;
        pulses += int'(on_frame_sent);
        chk("wrap_pulses", 32'(pulses), 17);
        chk("wrap_cnt", 32'(tx_frame_count), 1);

        link_status_raw = 1'b1;
        repeat (5) tick;
        chk("mid_link_up", 32'(has_link), 1);
        pulses = 0;
        rx_set(1, 1, 0, 0);
        tick;
        pulses += int'(on_frame_received);
        reset = 1'b1;
        tick;
        pulses += int'(on_frame_received);
        chk("mid_rst_link", 32'(has_link), 0);
        chk("mid_rst_tx_cnt", 32'(tx_frame_count), 0);
        reset = 1'b0;
        rx_set(1, 1, 1, 0);
        tick;
        pulses += int'(on_frame_received);
        chk("mid_rst_pulse", 32'(on_frame_received), 1);
        rx_set(0, 0, 0, 0);
        tick;
        pulses += int'(on_frame_received);
        chk("mid_rst_pulses", 32'(pulses), 1);
        chk("mid_rst_rx_cnt", 32'(rx_frame_count), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
